led_matrix_frame_capture: RTL

LED_MATRIX_FRAME_CAPTURE -- requirements
Module: led_matrix_frame_capture

---
 rtl/led_matrix_frame_capture.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/led_matrix_frame_capture.sv
// led_matrix_frame_capture
//   Reconstructs 8x8 frames from a scanned LED matrix drive. The scanned
//   row/column lines are registered once and debounced. Each stable new row
//   pattern is an "accept" event. Accepted rows are assembled in a shadow
//   buffer, in order from 0 to 7. Row 7 completes the frame and publishes it.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rowIn[7:0]   row select from the driver (active-high, one-hot when valid)
//   colIn[7:0]   column data for the selected row
//   frameOut     last complete frame, bit r*8+c = row r, column c (1 = lit)
//   frameValid   one-cycle pulse when frameOut is updated
//   frameCount   number of completed frames, wraps at 256
//   seqError     one-cycle pulse on an out-of-order row
//   rowError     one-cycle pulse on a stable non-one-hot, non-zero row
//   timeoutFlag  one-cycle pulse when the capture watchdog expires
module led_matrix_frame_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned COL_ACTIVE_LOW = 0,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rowIn,
    input  logic [7:0]  colIn,
    output logic [63:0] frameOut,
    output logic        frameValid,
    output logic [7:0]  frameCount,
    output logic        seqError,
    output logic        rowError,
    output logic        timeoutFlag
);

    localparam logic [0:0] SYNC    = 1'b0;
    localparam logic [0:0] CAPTURE = 1'b1;

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]      CNT_PRE  = 8'(STABLE_CYCLES - 2);

    logic [7:0]      sampleRow, sampleCol;
    logic [7:0]      prevRow, prevCol;
    logic [7:0]      stableCnt;
    logic [7:0]      lastRow;
    logic [63:0]     shadow;
    logic [2:0]      expIdx;
    logic [WD_W-1:0] watchdog;
    logic [0:0]      state;

    logic       sameSample;
    logic       acceptEvt;
    logic       rowOneHot;
    logic [2:0] rowIdx;
    logic [7:0] colNorm;

    assign sameSample = (sampleRow == prevRow) && (sampleCol == prevCol);
    // Fires on the single cycle where stableCnt steps onto its saturation value.
    assign acceptEvt  = sameSample && (stableCnt == CNT_PRE) && (sampleRow != lastRow);
    assign rowOneHot  = (sampleRow != 8'h00) && ((sampleRow & (sampleRow - 8'd1)) == 8'h00);
    assign colNorm    = (COL_ACTIVE_LOW != 0) ? ~sampleCol : sampleCol;

    always_comb begin
        rowIdx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (sampleRow[i]) rowIdx = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sampleRow   <= '0;
            sampleCol   <= '0;
            prevRow     <= '0;
            prevCol     <= '0;
            stableCnt   <= '0;
            lastRow     <= '0;
            shadow      <= '0;
            expIdx      <= '0;
            watchdog    <= '0;
            state       <= SYNC;
            frameOut    <= '0;
            frameValid  <= 1'b0;
            frameCount  <= '0;
            seqError    <= 1'b0;
            rowError    <= 1'b0;
            timeoutFlag <= 1'b0;
        end else begin
            sampleRow <= rowIn;
            sampleCol <= colIn;
            prevRow   <= sampleRow;
            prevCol   <= sampleCol;

            if (sameSample) begin
                if (stableCnt != CNT_LAST) stableCnt <= stableCnt + 8'd1;
            end else begin
                stableCnt <= '0;
            end

            frameValid  <= 1'b0;
            seqError    <= 1'b0;
            rowError    <= 1'b0;
            timeoutFlag <= 1'b0;

            if (acceptEvt) begin
                lastRow  <= sampleRow;
                watchdog <= '0;
                // An all-zero row is blanking: only lastRow and the watchdog react.
                if (sampleRow != 8'h00) begin
                    if (!rowOneHot) begin
                        rowError <= 1'b1;
                        state    <= SYNC;
                    end else if (state == SYNC) begin
                        if (rowIdx == 3'd0) begin
                            shadow[7:0] <= colNorm;
                            expIdx      <= 3'd1;
                            state       <= CAPTURE;
                        end
                    end else if (rowIdx == expIdx) begin
                        shadow[{expIdx, 3'b000} +: 8] <= colNorm;
                        expIdx <= expIdx + 3'd1;
                        if (expIdx == 3'd7) begin
                            // Row 7 is merged directly, the shadow copy lands on the same edge.
                            frameOut   <= {colNorm, shadow[55:0]};
                            frameValid <= 1'b1;
                            frameCount <= frameCount + 8'd1;
                        end
                    end else begin
                        seqError <= 1'b1;
                        if (rowIdx == 3'd0) begin
                            shadow[7:0] <= colNorm;
                            expIdx      <= 3'd1;
                        end else begin
                            state <= SYNC;
                        end
                    end
                end
            end else if (state == CAPTURE) begin
                if (watchdog == WD_LAST) begin
                    timeoutFlag <= 1'b1;
                    state       <= SYNC;
                    watchdog    <= '0;
                end else begin
                    watchdog <= watchdog + 1'b1;
                end
            end else begin
                watchdog <= '0;
            end
        end
    end

endmodule
